// File: rtl/trap_sequencer_if.sv
// Bus-side signal bundle for trap_sequencer: decode/opcode inputs and
// mapper-facing trap/control outputs.
interface trap_sequencer_if;
  logic       m1_n;
  logic       io_violation;
  logic       irq_sys_n;
  logic       ctrl_wr;
  logic [2:0] ctrl_data;
  logic       retn_fetch;
  logic       clr_stat;
  logic       virtual_enable;
  logic       trans_dir;
  logic       trap_state;
  logic       capture_addr;
  logic       nmi_n;
  logic       irq_n;
  logic       overrun;
  logic [3:0] trap_count;
  logic       wdt_fire;

  modport master (
    output m1_n, io_violation, irq_sys_n, ctrl_wr, ctrl_data, retn_fetch, clr_stat,
    input  virtual_enable, trans_dir, trap_state, capture_addr, nmi_n, irq_n,
           overrun, trap_count, wdt_fire
  );

  modport slave (
    input  m1_n, io_violation, irq_sys_n, ctrl_wr, ctrl_data, retn_fetch, clr_stat,
    output virtual_enable, trans_dir, trap_state, capture_addr, nmi_n, irq_n,
           overrun, trap_count, wdt_fire
  );
endinterface

// File: rtl/trap_sequencer.sv
// Hypervisor trap entry/exit sequencer for the MegaMapper CPLD.
// Define TRAP_WATCHDOG_EN to add the TRAPPED-state watchdog (WDT_CYCLES).
module trap_sequencer #(
  parameter int NMI_WIDTH = 4,
  parameter int EXIT_M1   = 1
`ifdef TRAP_WATCHDOG_EN
  , parameter int WDT_CYCLES = 65535
`endif
) (
  input logic        clk,
  input logic        reset,
  trap_sequencer_if.slave bus
);

  localparam int NMI_BITS = (NMI_WIDTH > 1) ? $clog2(NMI_WIDTH) : 1;
  localparam logic [NMI_BITS-1:0] NMI_LAST    = NMI_BITS'(NMI_WIDTH - 1);
  localparam logic [2:0]          EXIT_TARGET = 3'(EXIT_M1);

  typedef enum logic [2:0] {IDLE, CAPTURE, NMI, TRAPPED, EXIT} state_t;

  state_t              state, state_next;
  logic [NMI_BITS-1:0] nmi_cnt, nmi_cnt_next;
  logic [2:0]          m1_cnt, m1_cnt_next;
  logic                viol_q, m1_q;
  logic                virtual_enable, force_irq, trans_dir;
  logic                overrun, capture_addr, nmi_n, trap_state, irq_n;
  logic [3:0]          trap_count;
  logic                trap_start, wdt_expire, force_next, trap_next;
  logic                viol_edge, m1_fall;

`ifdef TRAP_WATCHDOG_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);
  logic [15:0] wdt_cnt, wdt_cnt_next;
  logic        wdt_fire_q;
`endif

  assign viol_edge = bus.io_violation & ~viol_q;
  assign m1_fall   = ~bus.m1_n & m1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      nmi_cnt <= '0;
      m1_cnt  <= '0;
`ifdef TRAP_WATCHDOG_EN
      wdt_cnt <= '0;
`endif
    end else begin
      state   <= state_next;
      nmi_cnt <= nmi_cnt_next;
      m1_cnt  <= m1_cnt_next;
`ifdef TRAP_WATCHDOG_EN
      wdt_cnt <= wdt_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    nmi_cnt_next = nmi_cnt;
    m1_cnt_next  = m1_cnt;
    trap_start   = 1'b0;
    wdt_expire   = 1'b0;
`ifdef TRAP_WATCHDOG_EN
    wdt_cnt_next = wdt_cnt;
`endif
    case (state)
      IDLE: begin
        // virtual_enable is the registered value, so a same-cycle ctrl_wr does not count
        if (viol_edge && virtual_enable) begin
          trap_start = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next   = NMI;
        nmi_cnt_next = '0;
      end
      NMI: begin
        if (nmi_cnt == NMI_LAST) begin
          state_next = TRAPPED;
`ifdef TRAP_WATCHDOG_EN
          wdt_cnt_next = '0;
`endif
        end else begin
          nmi_cnt_next = nmi_cnt + 1'b1;
        end
      end
      TRAPPED: begin
        if (bus.retn_fetch) begin
          state_next  = EXIT;
          m1_cnt_next = '0;
        end
`ifdef TRAP_WATCHDOG_EN
        else if (wdt_cnt == WDT_LAST) begin
          wdt_expire = 1'b1;
          state_next = IDLE;
        end else begin
          wdt_cnt_next = wdt_cnt + 16'd1;
        end
`endif
      end
      EXIT: begin
        if (m1_fall) begin
          if (m1_cnt + 3'd1 == EXIT_TARGET) state_next = IDLE;
          else m1_cnt_next = m1_cnt + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    force_next = bus.ctrl_wr ? bus.ctrl_data[1] : force_irq;
    trap_next  = state_next inside {NMI, TRAPPED, EXIT};
  end

  // Outputs are registered from next-state so they line up with the state change
  always_ff @(posedge clk) begin
    if (reset) begin
      viol_q         <= 1'b0;
      m1_q           <= 1'b1;
      virtual_enable <= 1'b0;
      force_irq      <= 1'b0;
      trans_dir      <= 1'b0;
      overrun        <= 1'b0;
      trap_count     <= '0;
      capture_addr   <= 1'b0;
      nmi_n          <= 1'b1;
      trap_state     <= 1'b0;
      irq_n          <= 1'b1;
    end else begin
      viol_q <= bus.io_violation;
      m1_q   <= bus.m1_n;
      if (bus.ctrl_wr) begin
        virtual_enable <= bus.ctrl_data[0];
        force_irq      <= bus.ctrl_data[1];
        trans_dir      <= bus.ctrl_data[2];
      end
      if (wdt_expire) virtual_enable <= 1'b0;
      // Set events take priority over clr_stat
      if (trap_start) begin
        if (trap_count != 4'd15) trap_count <= trap_count + 4'd1;
      end else if (bus.clr_stat) begin
        trap_count <= '0;
      end
      if ((viol_edge && state != IDLE) || wdt_expire) overrun <= 1'b1;
      else if (bus.clr_stat) overrun <= 1'b0;
      capture_addr <= (state_next == CAPTURE);
      nmi_n        <= (state_next != NMI);
      trap_state   <= trap_next;
      irq_n        <= trap_next ? bus.irq_sys_n : ~force_next;
    end
  end

`ifdef TRAP_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) wdt_fire_q <= 1'b0;
    else       wdt_fire_q <= wdt_expire;
  end
  assign bus.wdt_fire = wdt_fire_q;
`else
  assign bus.wdt_fire = 1'b0;
`endif

  assign bus.virtual_enable = virtual_enable;
  assign bus.trans_dir      = trans_dir;
  assign bus.trap_state     = trap_state;
  assign bus.capture_addr   = capture_addr;
  assign bus.nmi_n          = nmi_n;
  assign bus.irq_n          = irq_n;
  assign bus.overrun        = overrun;
  assign bus.trap_count     = trap_count;

endmodule
